// File: rtl/edge_pulser.sv
// edge_pulser: multi-channel input conditioner for board buttons/switches.
// Each channel synchronises its raw input, debounces it, and emits one-cycle
// pulses on the selected edges of the debounced level, with optional
// hold-to-repeat pulses while the level stays high.
//
// Ports:
//   clk    system clock, all state on posedge
//   rst    synchronous active-high reset
//   in     raw asynchronous inputs, one bit per channel
//   mode   per-channel edge select, [2i+1:2i] = {fall_en, rise_en}
//   level  debounced stable level per channel
//   pulse  one-cycle event pulse per channel
module edge_pulser #(
  parameter int N               = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = 10,
  parameter int REPEAT_PERIOD   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   in,
  input  logic [2*N-1:0] mode,
  output logic [N-1:0]   level,
  output logic [N-1:0]   pulse
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  // Last count before acceptance: the increment that would land on
  // DEBOUNCE_CYCLES accepts the new level instead.
  localparam logic [DBW-1:0] DB_TC = DBW'(DEBOUNCE_CYCLES - 1);

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [DBW-1:0]         db_cnt;
    logic                   level_q;
    logic                   level_d;
    logic                   pulse_q;
    logic                   rise_en;
    logic                   fall_en;
    logic                   rise;
    logic                   fall;
    logic                   rep_fire;

    assign sync_bit = sync_q[SYNC_STAGES-1];
    assign rise_en  = mode[2*i];
    assign fall_en  = mode[2*i+1];
    assign rise     = level_q & ~level_d;
    assign fall     = ~level_q & level_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], in[i]};
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        db_cnt  <= '0;
        level_q <= 1'b0;
      end else if (sync_bit == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_TC) begin
        level_q <= sync_bit;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // level_d lags level_q by one cycle, so the edge pulse appears on the
    // clock after the level change.
    always_ff @(posedge clk) begin
      if (rst) begin
        level_d <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        level_d <= level_q;
        pulse_q <= (rise & rise_en) | (fall & fall_en) | rep_fire;
      end
    end

    if (REPEAT_EN != 0) begin : g_rep
      localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int RW   = $clog2(RMAX + 1);
      localparam logic [RW-1:0] DLY_TC = RW'(REPEAT_DELAY - 1);
      localparam logic [RW-1:0] PER_TC = RW'(REPEAT_PERIOD - 1);

      logic [RW-1:0] rep_cnt;
      logic          rep_act;
      logic          rep_per;   // 0: waiting out the initial delay, 1: periodic
      logic          rep_hit;

      // Gating on level_q keeps a repeat off the cycle where a fall pulse
      // is due, since a fall pulse only issues once level_q is already 0.
      assign rep_hit  = rep_act & level_q & rise_en &
                        (rep_cnt == (rep_per ? PER_TC : DLY_TC));
      assign rep_fire = rep_hit;

      always_ff @(posedge clk) begin
        if (rst) begin
          rep_cnt <= '0;
          rep_act <= 1'b0;
          rep_per <= 1'b0;
        end else if (rise & rise_en) begin
          rep_cnt <= '0;
          rep_act <= 1'b1;
          rep_per <= 1'b0;
        end else if (!level_q || !rise_en) begin
          rep_cnt <= '0;
          rep_act <= 1'b0;
          rep_per <= 1'b0;
        end else if (rep_act) begin
          if (rep_hit) begin
            rep_cnt <= '0;
            rep_per <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
        end
      end
    end else begin : g_norep
      assign rep_fire = 1'b0;
    end

    assign level[i] = level_q;
    assign pulse[i] = pulse_q;
  end

endmodule

// File: tb/tb_edge_pulser.sv
// Directed bench for edge_pulser: two instances share stimulus, one without
// repeat logic (a) and one with repeat (b). Each table row applies inputs for
// n clock edges and checks the outputs after every one of them.
module tb_edge_pulser;

  logic       clk;
  logic       rst;
  logic [3:0] din;
  logic [7:0] mode;
  logic [3:0] level_a, pulse_a, level_b, pulse_b;

  int checks = 0;
  int errors = 0;

  edge_pulser #(.N(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
                .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_a (
    .clk(clk), .rst(rst), .in(din), .mode(mode), .level(level_a), .pulse(pulse_a));

  edge_pulser #(.N(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
                .REPEAT_DELAY(10), .REPEAT_PERIOD(5)) dut_b (
    .clk(clk), .rst(rst), .in(din), .mode(mode), .level(level_b), .pulse(pulse_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         n;
    logic       rst;
    logic [3:0] din;
    logic [7:0] mode;
    logic [3:0] lvl;
    logic [3:0] pa;
    logic [3:0] pb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic r, input logic [3:0] d, input logic [7:0] m,
                     input logic [3:0] lvl, input logic [3:0] pa, input logic [3:0] pb);
    vec_t v;
    v.n = n; v.rst = r; v.din = d; v.mode = m; v.lvl = lvl; v.pa = pa; v.pb = pb;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] lvl,
                           input logic [3:0] pa, input logic [3:0] pb);
    check({tag, ".level_a"}, level_a, lvl);
    check({tag, ".level_b"}, level_b, lvl);
    check({tag, ".pulse_a"}, pulse_a, pa);
    check({tag, ".pulse_b"}, pulse_b, pb);
  endtask

  initial begin
    rst = 1'b1; din = 4'b0000; mode = 8'h00;

    // A: ch0 rise-only, level after edge 6, pulse after edge 7, release later.
    add(2, 1, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0001, 4'b0001);
    add(3, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(5, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(5, 0, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);

    // B: 3-cycle bounce is rejected, then a clean press pulses once.
    add(1, 1, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(3, 0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0001, 4'b0001);
    add(2, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);

    // C: ch1 fall-only, press 20 cycles, pulse 7 edges after release.
    add(1, 1, 4'b0000, 8'h08, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0010, 8'h08, 4'b0000, 4'b0000, 4'b0000);
    add(15, 0, 4'b0010, 8'h08, 4'b0010, 4'b0000, 4'b0000);
    add(5, 0, 4'b0000, 8'h08, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h08, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h08, 4'b0000, 4'b0010, 4'b0010);
    add(2, 0, 4'b0000, 8'h08, 4'b0000, 4'b0000, 4'b0000);

    // D: ch1 both edges; b also repeats at 17 and 22, fall wins at 27.
    add(1, 1, 4'b0000, 8'h0C, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0010, 8'h0C, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0010, 8'h0C, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0010, 8'h0C, 4'b0010, 4'b0010, 4'b0010);
    add(9, 0, 4'b0010, 8'h0C, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0010, 8'h0C, 4'b0010, 4'b0000, 4'b0010);
    add(3, 0, 4'b0010, 8'h0C, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h0C, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h0C, 4'b0010, 4'b0000, 4'b0010);
    add(3, 0, 4'b0000, 8'h0C, 4'b0010, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h0C, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h0C, 4'b0000, 4'b0010, 4'b0010);
    add(2, 0, 4'b0000, 8'h0C, 4'b0000, 4'b0000, 4'b0000);

    // E: ch0 held, repeats at 17/22/27/32/37, stop on release (rise-only).
    add(1, 1, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0001, 8'h01, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0001, 4'b0001);
    add(9, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      add(4, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0000);
      add(1, 0, 4'b0001, 8'h01, 4'b0001, 4'b0000, 4'b0001);
    end
    add(4, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 4'b0000);
    add(1, 0, 4'b0000, 8'h01, 4'b0001, 4'b0000, 4'b0001);
    add(6, 0, 4'b0000, 8'h01, 4'b0000, 4'b0000, 4'b0000);

    // F: ch0 and ch2 rise together.
    add(1, 1, 4'b0000, 8'h11, 4'b0000, 4'b0000, 4'b0000);
    add(5, 0, 4'b0101, 8'h11, 4'b0000, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 8'h11, 4'b0101, 4'b0000, 4'b0000);
    add(1, 0, 4'b0101, 8'h11, 4'b0101, 4'b0101, 4'b0101);
    add(2, 0, 4'b0101, 8'h11, 4'b0101, 4'b0000, 4'b0000);

    foreach (tbl[r]) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        rst = tbl[r].rst; din = tbl[r].din; mode = tbl[r].mode;
        tick();
        check_all($sformatf("row%0d.c%0d", r, c), tbl[r].lvl, tbl[r].pa, tbl[r].pb);
      end
    end

    // Reset mid-operation with ch0 held high: fresh pulse 7 edges after release.
    rst = 1'b1; din = 4'b0000; mode = 8'h01;
    tick();
    rst = 1'b0; din = 4'b0001;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check_all($sformatf("pre_rst.e%0d", e), (e >= 6) ? 4'b0001 : 4'b0000,
                (e == 7) ? 4'b0001 : 4'b0000, (e == 7) ? 4'b0001 : 4'b0000);
    end
    rst = 1'b1;
    tick();
    check_all("mid_rst", 4'b0000, 4'b0000, 4'b0000);
    rst = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      check_all($sformatf("post_rst.e%0d", e), (e >= 6) ? 4'b0001 : 4'b0000,
                (e == 7) ? 4'b0001 : 4'b0000, (e == 7) ? 4'b0001 : 4'b0000);
    end

    // Clearing the rise bit just before the first repeat cancels it, and
    // setting it again while held does not re-arm repeats.
    rst = 1'b1; din = 4'b0000; mode = 8'h01;
    tick();
    rst = 1'b0; din = 4'b0001;
    for (int e = 1; e <= 16; e++) tick();
    check_all("held.e16", 4'b0001, 4'b0000, 4'b0000);
    mode = 8'h00;
    tick();
    check_all("rise_off.e17", 4'b0001, 4'b0000, 4'b0000);
    mode = 8'h01;
    for (int e = 18; e <= 30; e++) begin
      tick();
      check_all($sformatf("rearm.e%0d", e), 4'b0001, 4'b0000, 4'b0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
